// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter: two buffered write producers, round-robin onto one registered register-bank port.
// Latency: a write accepted at edge N drives WB_* after edge N+1 at the earliest; one grant per cycle.
// Backpressure: X_READY drops while that requester's buffer is full, even if it pops that cycle.

// Per-requester write buffer; also exposes every slot so the pending map can see all buffered writes.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push_rdy is low whenever the buffer is full, regardless of a same-cycle pop.
module regbank_wb_fifo #(
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  push_vld,
  output logic                  push_rdy,
  input  logic [AW-1:0]         push_addr,
  input  logic [DW-1:0]         push_dat,
  input  logic                  pop,
  output logic                  head_vld,
  output logic [AW-1:0]         head_addr,
  output logic [DW-1:0]         head_dat,
  output logic [DEPTH-1:0]      ent_vld,
  output logic [DEPTH*AW-1:0]   ent_addr
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] dat_q  [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          push_fire;
  logic          pop_fire;

  assign push_rdy  = (cnt != CW'(DEPTH));
  assign head_vld  = (cnt != '0);
  assign head_addr = addr_q[rd_ptr];
  assign head_dat  = dat_q[rd_ptr];
  assign push_fire = push_vld & push_rdy;
  assign pop_fire  = pop & head_vld;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_fire, pop_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset: slots are only observed through cnt.
  always_ff @(posedge CLK) begin
    if (push_fire) begin
      addr_q[wr_ptr] <= push_addr;
      dat_q[wr_ptr]  <= push_dat;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off                   = PW'(i) - rd_ptr;
    assign ent_vld[i]            = (CW'(off) < cnt);
    assign ent_addr[i*AW +: AW]  = addr_q[i];
  end
endmodule

// Write-back arbiter top: ALU (A) and load (M) buffers, round-robin grant, registered WB port, pending map.
// Latency: accept at edge N, WB_WE/ADDR/DATA valid after edge N+1; aggregate one write per cycle.
// Backpressure: A_READY/M_READY low while the respective buffer holds DEPTH entries.
module regbank_wb_arbiter #(
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                A_VALID,
  output logic                A_READY,
  input  logic [AW-1:0]       A_ADDR,
  input  logic [DW-1:0]       A_DATA,
  input  logic                M_VALID,
  output logic                M_READY,
  input  logic [AW-1:0]       M_ADDR,
  input  logic [DW-1:0]       M_DATA,
  output logic                WB_WE,
  output logic [AW-1:0]       WB_ADDR,
  output logic [DW-1:0]       WB_DATA,
  output logic [(1<<AW)-1:0]  PEND,
  output logic                IDLE
);
  typedef enum logic {LAST_A = 1'b0, LAST_M = 1'b1} last_t;

  last_t               last_q;
  last_t               last_nxt;
  logic                grant_a;
  logic                grant_m;
  logic                a_head_vld;
  logic                m_head_vld;
  logic [AW-1:0]       a_head_addr;
  logic [AW-1:0]       m_head_addr;
  logic [DW-1:0]       a_head_dat;
  logic [DW-1:0]       m_head_dat;
  logic [DEPTH-1:0]    a_ent_vld;
  logic [DEPTH-1:0]    m_ent_vld;
  logic [DEPTH*AW-1:0] a_ent_addr;
  logic [DEPTH*AW-1:0] m_ent_addr;

  regbank_wb_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_fifo_a (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push_vld  (A_VALID),
    .push_rdy  (A_READY),
    .push_addr (A_ADDR),
    .push_dat  (A_DATA),
    .pop       (grant_a),
    .head_vld  (a_head_vld),
    .head_addr (a_head_addr),
    .head_dat  (a_head_dat),
    .ent_vld   (a_ent_vld),
    .ent_addr  (a_ent_addr)
  );

  regbank_wb_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_fifo_m (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push_vld  (M_VALID),
    .push_rdy  (M_READY),
    .push_addr (M_ADDR),
    .push_dat  (M_DATA),
    .pop       (grant_m),
    .head_vld  (m_head_vld),
    .head_addr (m_head_addr),
    .head_dat  (m_head_dat),
    .ent_vld   (m_ent_vld),
    .ent_addr  (m_ent_addr)
  );

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_a  = 1'b0;
    grant_m  = 1'b0;
    last_nxt = last_q;
    if (a_head_vld && (!m_head_vld || last_q == LAST_M)) begin
      grant_a  = 1'b1;
      last_nxt = LAST_A;
    end else if (m_head_vld) begin
      grant_m  = 1'b1;
      last_nxt = LAST_M;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q  <= LAST_M;
      WB_WE   <= 1'b0;
      WB_ADDR <= '0;
      WB_DATA <= '0;
    end else begin
      last_q <= last_nxt;
      WB_WE  <= grant_a | grant_m;
      if (grant_a) begin
        WB_ADDR <= a_head_addr;
        WB_DATA <= a_head_dat;
      end else if (grant_m) begin
        WB_ADDR <= m_head_addr;
        WB_DATA <= m_head_dat;
      end
    end
  end

  // Pending covers every live buffer slot plus the write currently on the bank port.
  always_comb begin
    PEND = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ent_vld[i]) PEND[a_ent_addr[i*AW +: AW]] = 1'b1;
      if (m_ent_vld[i]) PEND[m_ent_addr[i*AW +: AW]] = 1'b1;
    end
    if (WB_WE) PEND[WB_ADDR] = 1'b1;
  end

  assign IDLE = !a_head_vld && !m_head_vld && !WB_WE;
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: directed scenarios plus random traffic against a queue-level model.
module tb_regbank_wb_arbiter;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          A_VALID = 1'b0, M_VALID = 1'b0;
  logic          A_READY, M_READY;
  logic [AW-1:0] A_ADDR = '0, M_ADDR = '0;
  logic [DW-1:0] A_DATA = '0, M_DATA = '0;
  logic          WB_WE;
  logic [AW-1:0] WB_ADDR;
  logic [DW-1:0] WB_DATA;
  logic [63:0]   PEND;
  logic          IDLE;

  int total = 0;
  int bad   = 0;

  regbank_wb_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_ADDR(M_ADDR), .M_DATA(M_DATA),
    .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .PEND(PEND), .IDLE(IDLE)
  );

  always #5 CLK = ~CLK;

  // Reference model: two bounded queues, a last-winner flag and the expected WB port.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          qa[$];
  ent_t          qm[$];
  bit            last_was_m;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  function automatic logic [63:0] exp_pend();
    logic [63:0] p = '0;
    foreach (qa[i]) p[qa[i].a] = 1'b1;
    foreach (qm[i]) p[qm[i].a] = 1'b1;
    if (exp_we) p[exp_addr] = 1'b1;
    return p;
  endfunction

  function automatic logic exp_idle();
    return (qa.size() == 0) && (qm.size() == 0) && !exp_we;
  endfunction

  task automatic model_reset();
    qa.delete();
    qm.delete();
    last_was_m = 1'b1;
    exp_we     = 1'b0;
    exp_addr   = '0;
    exp_data   = '0;
  endtask

  task automatic apply_reset();
    RST_N   = 1'b0;
    A_VALID = 1'b0;
    M_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, advance the model at the edge, return #1 after it.
  task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       output bit acc_a, output bit acc_m);
    bit ga, gm;
    A_VALID = av; A_ADDR = aa; A_DATA = ad;
    M_VALID = mv; M_ADDR = ma; M_DATA = md;
    acc_a = av && (qa.size() < DEPTH);
    acc_m = mv && (qm.size() < DEPTH);
    ga = (qa.size() > 0) && ((qm.size() == 0) || last_was_m);
    gm = !ga && (qm.size() > 0);
    @(posedge CLK);
    if (ga) begin
      exp_we = 1'b1; exp_addr = qa[0].a; exp_data = qa[0].d;
      void'(qa.pop_front()); last_was_m = 1'b0;
    end else if (gm) begin
      exp_we = 1'b1; exp_addr = qm[0].a; exp_data = qm[0].d;
      void'(qm.pop_front()); last_was_m = 1'b1;
    end else begin
      exp_we = 1'b0;
    end
    if (acc_a) qa.push_back('{a: aa, d: ad});
    if (acc_m) qm.push_back('{a: ma, d: md});
    #1;
    A_VALID = 1'b0;
    M_VALID = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (WB_WE !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", WB_WE); end
    total++; if (WB_ADDR !== '0 || WB_DATA !== '0) begin bad++; $display("FAIL reset_wb: got %0d/%h want 0/0", WB_ADDR, WB_DATA); end
    total++; if ({A_READY, M_READY} !== 2'b11) begin bad++; $display("FAIL reset_ready: got %b want 11", {A_READY, M_READY}); end
    total++; if (PEND !== 64'd0) begin bad++; $display("FAIL reset_pend: got %h want 0", PEND); end
    total++; if (IDLE !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", IDLE); end
  endtask

  task automatic test_single_write();
    bit xa, xm;
    apply_reset();
    cycle(1, 6'd5, 32'hDEADBEEF, 0, '0, '0, xa, xm);
    total++; if (WB_WE !== 1'b0) begin bad++; $display("FAIL single_early: got we=%b want 0", WB_WE); end
    total++; if (PEND[5] !== 1'b1) begin bad++; $display("FAIL single_pend: got %b want 1", PEND[5]); end
    cycle(0, '0, '0, 0, '0, '0, xa, xm);
    total++; if ({WB_WE, WB_ADDR, WB_DATA} !== {1'b1, 6'd5, 32'hDEADBEEF})
      begin bad++; $display("FAIL single_wb: got we=%b a=%0d d=%h want 1/5/deadbeef", WB_WE, WB_ADDR, WB_DATA); end
    cycle(0, '0, '0, 0, '0, '0, xa, xm);
    total++; if (WB_WE !== 1'b0 || IDLE !== 1'b1) begin bad++; $display("FAIL single_done: got we=%b idle=%b want 0/1", WB_WE, IDLE); end
    total++; if (PEND !== 64'd0) begin bad++; $display("FAIL single_pend_clr: got %h want 0", PEND); end
  endtask

  task automatic test_round_robin();
    int ai = 0, mi = 0;
    bit xa, xm, started = 0, gap = 0;
    int got[$];
    int want[6] = '{1, 11, 2, 12, 3, 13};
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(ai < 3, AW'(ai + 1), DW'(ai), mi < 3, AW'(mi + 11), DW'(mi), xa, xm);
      if (xa) ai++;
      if (xm) mi++;
      if (WB_WE) begin started = 1; got.push_back(int'(WB_ADDR)); end
      else if (started && got.size() < 6) gap = 1;
    end
    total++; if (got.size() != 6) begin bad++; $display("FAIL rr_count: got %0d want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      total++; if (got[i] != want[i]) begin bad++; $display("FAIL rr_seq[%0d]: got %0d want %0d", i, got[i], want[i]); end
    end
    total++; if (gap) begin bad++; $display("FAIL rr_gap: got gap=1 want 0"); end
  endtask

  task automatic test_back_pressure();
    int ai = 0, mi = 0;
    bit xa, xm, saw_low = 0;
    int got_a[$], got_m[$];
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      total++; if (M_READY !== (qm.size() < DEPTH)) begin bad++; $display("FAIL bp_mready c%0d: got %b want %b", c, M_READY, qm.size() < DEPTH); end
      if (M_READY === 1'b0) saw_low = 1;
      cycle(ai < 4, AW'(20 + ai), DW'(ai), mi < 4, AW'(30 + mi), DW'(100 + mi), xa, xm);
      if (xa) ai++;
      if (xm) mi++;
      if (WB_WE) begin
        if (WB_ADDR >= 30) got_m.push_back(int'(WB_ADDR)); else got_a.push_back(int'(WB_ADDR));
      end
    end
    total++; if (!saw_low) begin bad++; $display("FAIL bp_full: got M_READY never 0 want a 0"); end
    total++; if (got_m.size() != 4 || got_a.size() != 4) begin bad++; $display("FAIL bp_count: got %0d/%0d want 4/4", got_a.size(), got_m.size()); end
    for (int i = 0; i < 4 && i < got_m.size(); i++) begin
      total++; if (got_m[i] != 30 + i) begin bad++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, got_m[i], 30 + i); end
    end
  endtask

  task automatic test_same_addr();
    bit xa, xm;
    logic [DW-1:0] want_d[2] = '{32'h1, 32'h2};
    apply_reset();
    cycle(1, 6'd7, 32'h1, 0, '0, '0, xa, xm);
    cycle(0, '0, '0, 1, 6'd7, 32'h2, xa, xm);
    for (int i = 0; i < 2; i++) begin
      total++; if (PEND[7] !== 1'b1) begin bad++; $display("FAIL same_pend[%0d]: got %b want 1", i, PEND[7]); end
      total++; if ({WB_WE, WB_ADDR, WB_DATA} !== {1'b1, 6'd7, want_d[i]})
        begin bad++; $display("FAIL same_wb[%0d]: got we=%b a=%0d d=%h want 1/7/%h", i, WB_WE, WB_ADDR, WB_DATA, want_d[i]); end
      cycle(0, '0, '0, 0, '0, '0, xa, xm);
    end
    total++; if (PEND[7] !== 1'b0 || WB_WE !== 1'b0) begin bad++; $display("FAIL same_clr: got pend=%b we=%b want 0/0", PEND[7], WB_WE); end
  endtask

  task automatic test_reset_midop();
    bit xa, xm;
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1, AW'(50 + 2*i), DW'(i), 1, AW'(51 + 2*i), DW'(i), xa, xm);
    total++; if (WB_WE !== 1'b1) begin bad++; $display("FAIL mid_busy: got we=%b want 1", WB_WE); end
    #2; RST_N = 1'b0; #1;
    total++; if (WB_WE !== 1'b0) begin bad++; $display("FAIL mid_we: got %b want 0", WB_WE); end
    total++; if ({A_READY, M_READY} !== 2'b11) begin bad++; $display("FAIL mid_ready: got %b want 11", {A_READY, M_READY}); end
    total++; if (PEND !== 64'd0) begin bad++; $display("FAIL mid_pend: got %h want 0", PEND); end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, '0, 0, '0, '0, xa, xm);
      total++; if (WB_WE !== 1'b0 || IDLE !== 1'b1) begin bad++; $display("FAIL mid_stale[%0d]: got we=%b idle=%b want 0/1", i, WB_WE, IDLE); end
    end
    cycle(1, 6'd40, 32'hA, 1, 6'd41, 32'hB, xa, xm);
    cycle(0, '0, '0, 0, '0, '0, xa, xm);
    total++; if ({WB_WE, WB_ADDR} !== {1'b1, 6'd40}) begin bad++; $display("FAIL mid_last: got we=%b a=%0d want 1/40", WB_WE, WB_ADDR); end
  endtask

  task automatic test_push_pop_count1();
    bit xa, xm;
    apply_reset();
    cycle(1, 6'd0, 32'd0, 0, '0, '0, xa, xm);
    for (int i = 1; i < 8; i++) begin
      total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL pp_ready[%0d]: got %b want 1", i, A_READY); end
      cycle(1, AW'(i), DW'(i * 3), 0, '0, '0, xa, xm);
      total++; if ({WB_WE, WB_ADDR, WB_DATA} !== {1'b1, AW'(i - 1), DW'((i - 1) * 3)})
        begin bad++; $display("FAIL pp_wb[%0d]: got we=%b a=%0d d=%0d want 1/%0d/%0d", i, WB_WE, WB_ADDR, WB_DATA, i - 1, (i - 1) * 3); end
    end
  endtask

  task automatic test_random();
    bit xa, xm;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      total++; if ({A_READY, M_READY} !== {qa.size() < DEPTH, qm.size() < DEPTH})
        begin bad++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, A_READY, M_READY, qa.size() < DEPTH, qm.size() < DEPTH); end
      cycle($urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), DW'($urandom),
            $urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), DW'($urandom), xa, xm);
      total++; if (WB_WE !== exp_we) begin bad++; $display("FAIL rnd_we c%0d: got %b want %b", c, WB_WE, exp_we); end
      total++; if (WB_ADDR !== exp_addr || WB_DATA !== exp_data)
        begin bad++; $display("FAIL rnd_wb c%0d: got %0d/%h want %0d/%h", c, WB_ADDR, WB_DATA, exp_addr, exp_data); end
      total++; if (PEND !== exp_pend()) begin bad++; $display("FAIL rnd_pend c%0d: got %h want %h", c, PEND, exp_pend()); end
      total++; if (IDLE !== exp_idle()) begin bad++; $display("FAIL rnd_idle c%0d: got %b want %b", c, IDLE, exp_idle()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_back_pressure();
    test_same_addr();
    test_reset_midop();
    test_push_pop_count1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regbank_wb_arbiter.md
# regbank_wb_arbiter

Write-back arbiter for the 64×32 register bank. Two producers, the ALU result path (A) and the memory load path (M), each push write requests through a valid/ready handshake into a small per-requester buffer. The block grants one buffered write per cycle using round-robin and drives a single registered write port into the register bank. It also exports a per-register pending map so decode can stall on outstanding writes.

## Interface
- AW, 6, register address width (2^AW registers)
- DW, 32, data width
- DEPTH, 2, entries per requester buffer (power of two, ≥2)

- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- A_VALID  in  1  ALU write request valid
- A_READY  out  1  ALU buffer can accept
- A_ADDR  in  AW  ALU destination register
- A_DATA  in  DW  ALU write data
- M_VALID  in  1  memory-load write request valid
- M_READY  out  1  memory buffer can accept
- M_ADDR  in  AW  load destination register
- M_DATA  in  DW  load write data
- WB_WE  out  1  register bank write enable (registered)
- WB_ADDR  out  AW  register bank write address (registered)
- WB_DATA  out  DW  register bank write data (registered)
- PEND  out  2^AW  bit r set while any write to register r is buffered or on WB_*
- IDLE  out  1  both buffers empty and WB_WE low

## Operation
- Each requester owns a DEPTH-entry FIFO holding {addr, data}, with read/write pointers that wrap modulo DEPTH and a count of 0..DEPTH.
- Push: at a rising edge with X_VALID & X_READY, the request is written at the tail.
- X_READY = (count_X != DEPTH). It is combinational from state only, never from the same-cycle pop. A full buffer refuses a push even when it pops in that cycle.
- Push and pop on the same edge: count unchanged; legal whenever count ≥ 1.
- Arbiter state LAST ∈ {A, M} records the last granted requester. Each cycle:
  - neither buffer non-empty → no grant, WB_WE←0;
  - exactly one non-empty → grant it;
  - both non-empty → grant the requester ≠ LAST.
- On a grant: pop the head, load WB_ADDR/WB_DATA from it, set WB_WE←1, set LAST←granted.
- With no grant, WB_ADDR/WB_DATA hold their previous values.
- Order within a requester is strict FIFO. Across requesters, writes to the same address land in grant order. The last granted write wins in the register bank.
- PEND is combinational: the OR over all valid entries in both FIFOs plus {WB_WE, WB_ADDR}. Address 0 is an ordinary register.
- IDLE = (count_A==0) & (count_M==0) & !WB_WE.
- A request with X_VALID low is ignored. X_ADDR/X_DATA are don't-care then.

## Timing
- Reset (RST_N low, asynchronous): counts 0, pointers 0, WB_WE 0, WB_ADDR 0, WB_DATA 0, LAST=M (so A wins the first tie).
- Reset outputs: A_READY=M_READY=1, PEND all 0, IDLE=1.
- Reset mid-operation discards all buffered and in-flight writes. No WB_WE is produced for them.
- Latency: a request accepted at edge N appears on WB_* after edge N+1 at the earliest. The register bank writes it at edge N+2.
- Throughput: one write per cycle aggregate. With both requesters saturated, each gets every other cycle.
- Worst-case wait for a non-empty head is 1 cycle, because round-robin guarantees no starvation.
- PEND[r] rises in the cycle after the accepting edge. It falls in the cycle after the edge where WB_WE for the last write to r deasserts, or where its slot is replaced by a write to another address.

## Test plan
- Single write: A pushes addr 5, data 0xDEADBEEF at edge 1 → WB_WE=1, WB_ADDR=5, WB_DATA=0xDEADBEEF after edge 2; WB_WE=0 after edge 3; IDLE=1 after edge 3.
- Tie and round-robin: A and M both push every cycle (A addr 1,2,3; M addr 11,12,13) → WB_ADDR sequence 1,11,2,12,3,13, with no gaps after the first grant.
- Back-pressure: M pushes 4 requests back-to-back while A is also busy → M_READY drops to 0 when count_M=2; no request is lost; all 4 appear on WB_* in order.
- Same-address ordering: A pushes r7=0x1 at edge 1, M pushes r7=0x2 at edge 2 → WB writes 0x1, then 0x2. PEND[7]=1 from after edge 2 until WB_WE for 0x2 deasserts.
- Reset mid-op: fill both buffers, pull RST_N low asynchronously between edges → WB_WE=0, both READYs=1, PEND=0 immediately. After release, no stale write appears and LAST=M.
- Simultaneous push/pop at count=1: A sustains one push per cycle with M idle → count_A stays at 1, A_READY stays 1, and one WB_WE is produced per cycle.
